serial_frame_loader: RTL

- Parametrised successor to the single-stream serial input block. It deserialises a 1-bit stream into WORD_W-bit words, organised as cfg_num_dp+1 datapoints of cfg_feat+1 features each.
- Each assembled word goes to a data memory through a one-cycle write strobe. The address is computed as datapoint*MAX_FEAT + feature.
- Adds a per-bit qualifier (ser_valid), selectable bit order, a start/busy/done handshake and configuration range checking.
- Sits between the external serial link and the feature/datapoint RAM feeding the compute core.

---
 rtl/serial_frame_loader_if.sv | 35 +++
 rtl/serial_frame_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_loader_if.sv
// Bundle between the serial link / controller side (master) and the frame loader (slave).
// The widths are derived from the same parameters that the loader is built with.
interface serial_frame_loader_if #(
    parameter int WORD_W   = 16,
    parameter int MAX_FEAT = 16,
    parameter int MAX_DP   = 8
);
    localparam int FEAT_W = $clog2(MAX_FEAT);
    localparam int DP_W   = $clog2(MAX_DP);
    localparam int ADDR_W = $clog2(MAX_FEAT * MAX_DP);

    logic              start;
    logic [DP_W-1:0]   cfg_num_dp;
    logic [FEAT_W-1:0] cfg_feat;
    logic              cfg_msb_first;
    logic              ser;
    logic              ser_valid;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, cfg_num_dp, cfg_feat, cfg_msb_first, ser, ser_valid,
        input  wr_en, wr_addr, wr_data, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_num_dp, cfg_feat, cfg_msb_first, ser, ser_valid,
        output wr_en, wr_addr, wr_data, busy, done, cfg_err
    );
endinterface

// File: rtl/serial_frame_loader.sv
// Deserialises a qualified 1-bit stream into words and writes them to the datapoint/feature RAM
// at datapoint*MAX_FEAT + feature; features run high-to-low, datapoints low-to-high.
module serial_frame_loader #(
    parameter int WORD_W   = 16,
    parameter int MAX_FEAT = 16,
    parameter int MAX_DP   = 8
) (
    input  logic CLK,
    input  logic RST,
    serial_frame_loader_if.slave bus
);
    localparam int FEAT_W = $clog2(MAX_FEAT);
    localparam int DP_W   = $clog2(MAX_DP);
    localparam int ADDR_W = $clog2(MAX_FEAT * MAX_DP);
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(MAX_FEAT);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DP_W-1:0]   cfg_num_dp_reg, cfg_num_dp_next;
    logic [FEAT_W-1:0] cfg_feat_reg, cfg_feat_next;
    logic              msb_first_reg, msb_first_next;
    logic [DP_W-1:0]   dp_cnt_reg, dp_cnt_next;
    logic [FEAT_W-1:0] feat_cnt_reg, feat_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [WORD_W-1:0] wr_data_reg, wr_data_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              cfg_err_reg, cfg_err_next;

    logic              feat_ok;
    logic              dp_ok;
    logic [WORD_W-1:0] word_lsb_first;
    logic [WORD_W-1:0] word_msb_first;
    logic [WORD_W-1:0] word_assembled;
    logic [ADDR_W-1:0] slot_addr;

    // A power-of-two depth means every encodable cfg value is legal, so no comparator is built.
    generate
        if ((MAX_FEAT & (MAX_FEAT - 1)) == 0) begin : g_feat_pow2
            assign feat_ok = 1'b1;
        end else begin : g_feat_chk
            assign feat_ok = (bus.cfg_feat <= FEAT_W'(MAX_FEAT - 1));
        end

        if ((MAX_DP & (MAX_DP - 1)) == 0) begin : g_dp_pow2
            assign dp_ok = 1'b1;
        end else begin : g_dp_chk
            assign dp_ok = (bus.cfg_num_dp <= DP_W'(MAX_DP - 1));
        end
    endgenerate

    // Candidate next shift values: LSB-first shifts right (new bit on top), MSB-first shifts left.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_shift
            if (gi == WORD_W - 1) begin : g_lsb_top
                assign word_lsb_first[gi] = bus.ser;
            end else begin : g_lsb_mid
                assign word_lsb_first[gi] = shift_reg[gi + 1];
            end

            if (gi == 0) begin : g_msb_bot
                assign word_msb_first[gi] = bus.ser;
            end else begin : g_msb_mid
                assign word_msb_first[gi] = shift_reg[gi - 1];
            end
        end
    endgenerate

    assign word_assembled = msb_first_reg ? word_msb_first : word_lsb_first;
    assign slot_addr      = ADDR_W'(dp_cnt_reg) * STRIDE + ADDR_W'(feat_cnt_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            cfg_num_dp_reg <= '0;
            cfg_feat_reg   <= '0;
            msb_first_reg  <= 1'b0;
            dp_cnt_reg     <= '0;
            feat_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cfg_num_dp_reg <= cfg_num_dp_next;
            cfg_feat_reg   <= cfg_feat_next;
            msb_first_reg  <= msb_first_next;
            dp_cnt_reg     <= dp_cnt_next;
            feat_cnt_reg   <= feat_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            cfg_err_reg    <= cfg_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cfg_num_dp_next = cfg_num_dp_reg;
        cfg_feat_next   = cfg_feat_reg;
        msb_first_next  = msb_first_reg;
        dp_cnt_next     = dp_cnt_reg;
        feat_cnt_next   = feat_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        cfg_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (feat_ok && dp_ok) begin
                        cfg_num_dp_next = bus.cfg_num_dp;
                        cfg_feat_next   = bus.cfg_feat;
                        msb_first_next  = bus.cfg_msb_first;
                        dp_cnt_next     = '0;
                        feat_cnt_next   = bus.cfg_feat;
                        bit_cnt_next    = '0;
                        shift_next      = '0;
                        done_next       = 1'b0;
                        busy_next       = 1'b1;
                        state_next      = LOAD;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (bus.ser_valid) begin
                    shift_next = word_assembled;
                    if (bit_cnt_reg == LAST_BIT) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = word_assembled;
                        wr_addr_next = slot_addr;
                        bit_cnt_next = '0;
                        if (feat_cnt_reg == '0) begin
                            feat_cnt_next = cfg_feat_reg;
                            dp_cnt_next   = dp_cnt_reg + DP_W'(1);
                            if (dp_cnt_reg == cfg_num_dp_reg) begin
                                state_next = FIN;
                            end
                        end else begin
                            feat_cnt_next = feat_cnt_reg - FEAT_W'(1);
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end

            FIN: begin
                // The final write strobe is visible during this cycle; completion flags follow.
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_addr = wr_addr_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.cfg_err = cfg_err_reg;
endmodule
